adder_seq_16b: RTL and testbench



---
 rtl/adder_seq_16b_pkg.sv | 32 +++
 rtl/adder_seq_16b_rca4.sv | 34 +++
 rtl/adder_seq_16b.sv | 146 ++++++++++++++
 tb/tb_adder_seq_16b.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_16b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_16b_pkg
//  Description : Shared types and constants for the nibble-serial 16-bit
//                adder: control state encoding and nibble geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package adder_seq_16b_pkg;

   // Number of nibbles making up one operand, and the width of each nibble.
   localparam int NIBBLE_COUNT = 4;
   localparam int NIBBLE_WIDTH = 4;
   localparam int DATA_WIDTH   = NIBBLE_COUNT * NIBBLE_WIDTH;

   // Index value of the most significant nibble; reaching it ends a calculation.
   localparam logic [1:0] LAST_NIBBLE = 2'(NIBBLE_COUNT - 1);

   // Control states: waiting for operands, stepping through nibbles, and
   // presenting a finished result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit offset of the least significant bit of nibble idx.
   function automatic logic [3:0] nibble_lsb(input logic [1:0] idx);
      return {idx, 2'b00};
   endfunction

endpackage : adder_seq_16b_pkg
`default_nettype wire

// File: rtl/adder_seq_16b_rca4.sv
`default_nettype none
// ============================================================================
//  Module      : AdderRippleCarry_4b_GL
//  Description : 4-bit ripple-carry adder built from gate-level full adders.
//                Purely combinational; the carry ripples bit 0 -> bit 3.
//  Revision    : 1.0  initial release
// ============================================================================
module AdderRippleCarry_4b_GL
   import adder_seq_16b_pkg::*;
(
   input  logic [NIBBLE_WIDTH-1:0] in0,
   input  logic [NIBBLE_WIDTH-1:0] in1,
   input  logic                    cin,
   output logic [NIBBLE_WIDTH-1:0] sum,
   output logic                    cout
);

   // Carry chain: w_carry[i] enters bit i, w_carry[NIBBLE_WIDTH] leaves bit 3.
   logic [NIBBLE_WIDTH:0] w_carry;

   assign w_carry[0] = cin;

   // One full adder per bit, expressed with AND/OR/XOR gates.
   for (genvar i = 0; i < NIBBLE_WIDTH; i++) begin : g_bit
      logic w_half;
      assign w_half         = in0[i] ^ in1[i];
      assign sum[i]         = w_half ^ w_carry[i];
      assign w_carry[i + 1] = (in0[i] & in1[i]) | (w_half & w_carry[i]);
   end

   assign cout = w_carry[NIBBLE_WIDTH];

endmodule : AdderRippleCarry_4b_GL
`default_nettype wire

// File: rtl/adder_seq_16b.sv
`default_nettype none
// ============================================================================
//  Module      : adder_seq_16b
//  Description : Sequential 16-bit adder. One shared 4-bit ripple-carry adder
//                is applied to one nibble per cycle, LSB nibble first, with
//                the carry held in a register between nibbles. Operands
//                arrive on a val/rdy input stream; sum and carry-out leave on
//                a val/rdy output stream.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_seq_16b
   import adder_seq_16b_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  istream_val,
   output logic                  istream_rdy,
   input  logic [DATA_WIDTH-1:0] in0,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic                  cin,

   output logic                  ostream_val,
   input  logic                  ostream_rdy,
   output logic [DATA_WIDTH-1:0] sum,
   output logic                  cout
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_next;

   logic [DATA_WIDTH-1:0]   r_op_a;     // operand A captured at accept
   logic [DATA_WIDTH-1:0]   r_op_b;     // operand B captured at accept
   logic [1:0]              r_idx;      // nibble currently being added
   logic                    r_carry;    // carry into the current nibble
   logic [DATA_WIDTH-1:0]   r_sum;      // result, filled nibble by nibble
   logic                    r_cout;     // carry out of bit 15 of last result

   // ------------------------------------------------------------------------
   // Nibble datapath around the shared 4-bit adder
   // ------------------------------------------------------------------------
   logic [3:0]              w_lsb;
   logic [NIBBLE_WIDTH-1:0] w_nib_a;
   logic [NIBBLE_WIDTH-1:0] w_nib_b;
   logic [NIBBLE_WIDTH-1:0] w_nib_sum;
   logic                    w_nib_cout;

   logic                    w_accept;
   logic                    w_last_nibble;

   assign w_lsb         = nibble_lsb(r_idx);
   assign w_nib_a       = r_op_a[w_lsb +: NIBBLE_WIDTH];
   assign w_nib_b       = r_op_b[w_lsb +: NIBBLE_WIDTH];
   assign w_last_nibble = (r_idx == LAST_NIBBLE);

   AdderRippleCarry_4b_GL u_rca4 (
      .in0  (w_nib_a),
      .in1  (w_nib_b),
      .cin  (r_carry),
      .sum  (w_nib_sum),
      .cout (w_nib_cout)
   );

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs; outputs depend on state only.
   always_comb begin
      w_state_next = r_state;
      istream_rdy  = 1'b0;
      ostream_val  = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) begin
               w_accept     = 1'b1;
               w_state_next = CALC;
            end
         end
         CALC: begin
            if (w_last_nibble) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------

   // Capture operands on accept, then fold in one nibble per CALC cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_idx   <= 2'd0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_op_a  <= in0;
         r_op_b  <= in1;
         r_carry <= cin;
         r_idx   <= 2'd0;
      end else if (r_state == CALC) begin
         r_sum[w_lsb +: NIBBLE_WIDTH] <= w_nib_sum;
         r_carry                      <= w_nib_cout;
         r_idx                        <= r_idx + 2'd1;
         // The carry out of the top nibble is the result carry; it is kept
         // separately so a new accept (which reloads r_carry) leaves the
         // previous cout visible.
         if (w_last_nibble) begin
            r_cout <= w_nib_cout;
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule : adder_seq_16b
`default_nettype wire

// File: tb/tb_adder_seq_16b.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_seq_16b
//  Description : Self-checking bench for adder_seq_16b: directed vectors with
//                hand-computed sums, backpressure, operand disturbance during
//                a calculation, mid-calculation reset and back-to-back ops.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adder_seq_16b;

   logic        clk;
   logic        reset;
   logic        istream_val;
   logic        istream_rdy;
   logic [15:0] in0;
   logic [15:0] in1;
   logic        cin;
   logic        ostream_val;
   logic        ostream_rdy;
   logic [15:0] sum;
   logic        cout;

   int n_checks;
   int n_pass;
   int cyc;
   int last_acc;

   adder_seq_16b dut (
      .clk         (clk),
      .reset       (reset),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .in0         (in0),
      .in1         (in1),
      .cin         (cin),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .sum         (sum),
      .cout        (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter used to measure operation spacing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample/drive 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation. hold = cycles of ostream_rdy low after val rises.
   // disturb = wiggle the input stream during CALC/DONE.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es, input logic ec,
                        input int hold, input bit disturb);
      int  lat;
      bit  rdy_bad;
      chk({tag, " idle_rdy"}, 32'(istream_rdy), 32'd1);
      istream_val = 1'b1;
      in0         = a;
      in1         = b;
      cin         = c;
      ostream_rdy = (hold == 0);
      last_acc    = cyc;
      step();                                   // accept edge -> cycle 1
      if (disturb) begin
         in0 = 16'hFFFF;
         in1 = 16'h5A5A;
         cin = 1'b1;
      end else begin
         istream_val = 1'b0;
      end
      lat     = -1;
      rdy_bad = 1'b0;
      for (int k = 1; k <= 12 && lat < 0; k++) begin
         if (istream_rdy) rdy_bad = 1'b1;
         if (ostream_val) lat = k;
         else step();
      end
      chk({tag, " latency"}, 32'(lat), 32'd5);
      chk({tag, " rdy_low"}, 32'(rdy_bad), 32'd0);
      chk({tag, " sum"}, 32'(sum), 32'(es));
      chk({tag, " cout"}, 32'(cout), 32'(ec));
      for (int h = 0; h < hold; h++) begin
         step();
         chk({tag, " bp_val"}, 32'(ostream_val), 32'd1);
         chk({tag, " bp_sum"}, 32'(sum), 32'(es));
         chk({tag, " bp_irdy"}, 32'(istream_rdy), 32'd0);
      end
      ostream_rdy = 1'b1;
      step();                                   // DONE handshake -> IDLE
      chk({tag, " back_idle"}, 32'(istream_rdy), 32'd1);
      chk({tag, " val_drop"}, 32'(ostream_val), 32'd0);
      chk({tag, " sum_kept"}, 32'(sum), 32'(es));
      istream_val = 1'b0;
   endtask

   logic [16:0] ref17;
   logic [15:0] ra, rb;
   logic        rc;
   int          prev_acc;

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      cyc         = 0;
      last_acc    = 0;
      reset       = 1'b1;
      istream_val = 1'b0;
      ostream_rdy = 1'b0;
      in0         = '0;
      in1         = '0;
      cin         = 1'b0;
      step();
      step();
      chk("rst irdy", 32'(istream_rdy), 32'd1);
      chk("rst oval", 32'(ostream_val), 32'd0);
      chk("rst sum", 32'(sum), 32'd0);
      chk("rst cout", 32'(cout), 32'd0);
      reset = 1'b0;
      step();

      // Directed vectors (hand-computed sums).
      do_op("00ff_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 1'b0);
      do_op("ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
      do_op("ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0, 1'b0);
      do_op("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
      do_op("0000_0000_c", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 0, 1'b0);
      do_op("bp_1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 3, 1'b0);
      do_op("dist_0f0f_0101", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 0, 1'b1);

      // Reset during the second CALC cycle discards the operation.
      istream_val = 1'b1;
      in0         = 16'hFFFF;
      in1         = 16'hFFFF;
      cin         = 1'b1;
      ostream_rdy = 1'b0;
      step();                                   // accepted -> CALC cycle 1
      istream_val = 1'b0;
      step();                                   // CALC cycle 2
      chk("midrst busy", 32'(istream_rdy), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst irdy", 32'(istream_rdy), 32'd1);
      chk("midrst oval", 32'(ostream_val), 32'd0);
      chk("midrst sum", 32'(sum), 32'd0);
      chk("midrst cout", 32'(cout), 32'd0);
      do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0, 1'b0);

      // Back-to-back random operations; expected from a 17-bit reference.
      prev_acc = -1;
      for (int i = 0; i < 20; i++) begin
         ra    = 16'($urandom);
         rb    = 16'($urandom);
         rc    = 1'($urandom);
         ref17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         do_op($sformatf("rnd%0d", i), ra, rb, rc, ref17[15:0], ref17[16], 0, 1'b0);
         if (prev_acc >= 0) chk($sformatf("rnd%0d spacing", i), 32'(last_acc - prev_acc), 32'd6);
         prev_acc = last_acc;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_adder_seq_16b
`default_nettype wire
